game_timer_ctrl: RTL and testbench
==================================

Name: game_timer_ctrl

Overview:
- Sequencing controller for the on-screen HH:MM:SS time display. It owns the run/pause/stop state of the game timer and the 1 Hz prescaler.
- Maintains two six-digit BCD time sets: the live run time and the best (lowest) completed time. These drive the two stacked time rows of the time renderer.
- Sits between game logic (start/stop/clear events, pause switch) and the time-render block.

Parameters:
- TICK_DIV, 100_000_000, clk cycles per counted second (≥2). Benches use 4.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse: begin a new run from 00:00:00
- stop  in  1  one-cycle pulse: run completed (frog reached goal)
- clear  in  1  one-cycle pulse: abandon run, zero live time, return to IDLE
- pause_sw  in  1  level: 1 = hold counting
- sec_1s, sec_10s, min_1s, min_10s, hr_1s, hr_10s  out  4 each  live time, BCD
- best_sec_1s, best_sec_10s, best_min_1s, best_min_10s, best_hr_1s, best_hr_10s  out  4 each  best time, BCD
- best_valid  out  1  best time holds a completed run
- new_best  out  1  one-cycle pulse: best time just updated
- running  out  1  state is RUN
- tick_1Hz  out  1  one-cycle pulse on each counted second (for colon blink)
- overflow  out  1  sticky: live time saturated at 99:59:59

Behaviour:
- All outputs are registered. On reset, every output is 0, the state is IDLE and the prescaler is 0.
- States:
  - IDLE: start -> RUN.
  - RUN:
    - stop -> DONE
    - clear -> IDLE
    - start is ignored
    - pause_sw=1 -> PAUSED
  - PAUSED:
    - pause_sw=0 -> RUN
    - stop -> DONE
    - clear -> IDLE
    - start is ignored
  - DONE:
    - start -> RUN
    - clear -> IDLE
- Event priority within one cycle: clear > stop > start > pause_sw.
- Transition actions:
  - start accepted: live time := 0, prescaler := 0, overflow := 0.
  - clear: live time := 0, prescaler := 0, overflow := 0. Best time is unaffected.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN. It holds its value in PAUSED, IDLE and DONE; it does not reset on pause.
  - On the edge where it wraps from TICK_DIV-1 to 0, tick_1Hz=1 and the live time increments, both visible in the same following cycle.
  - First tick after start: TICK_DIV cycles after the cycle in which start is sampled.
- BCD increment:
  - sec_1s 9->0 carries to sec_10s; sec_10s 5->0 carries to min_1s.
  - min_1s 9->0 carries to min_10s; min_10s 5->0 carries to hr_1s.
  - hr_1s 9->0 carries to hr_10s.
  - Digits never hold non-BCD values.
- Saturation: at 99:59:59 further ticks leave the time unchanged and set overflow. tick_1Hz still pulses.
- Stop cycle:
  - If stop coincides with a prescaler wrap, the increment is suppressed. The final time is the value held in the stop cycle, and tick_1Hz does not pulse.
- Best update on entry to DONE:
  - Compare the packed 24-bit {hr_10s..sec_1s} numerically; BCD ordering equals numeric ordering.
  - If best_valid=0 or final < best: best := final, best_valid := 1, and new_best pulses for exactly one cycle, coincident with the updated best outputs.
  - Equal or greater: no change.
  - overflow=1 at stop: never a new best.
- running is 1 in RUN only.
- Asynchronous reset mid-run: immediate return to reset values, including best_valid=0.

Decomposition:
- Shared package:
  - state encoding (IDLE=0, RUN=1, PAUSED=2, DONE=3)
  - TIME_MAX_BCD=24'h995959
  - BCD digit limits (9, 5)
- Sub-module bcd_hms_counter: six-digit BCD HH:MM:SS register with inc, clr, saturation and a 24-bit packed output.
- Prescaler, FSM and best-compare logic stay in game_timer_ctrl.

Test Plan:
- TICK_DIV=4: reset; start -> running=1. tick_1Hz pulses every 4 cycles; sec_1s reads 1,2,…,9 then sec_10s=1, sec_1s=0 after the 10th tick.
- Preload 00:59:59 via ticks; one more tick -> 01:00:00. Preload 99:59:59; further ticks -> unchanged, overflow=1, tick_1Hz still pulsing.
- pause_sw=1 for 10 cycles mid-second (prescaler=2) -> digits and prescaler frozen, no tick. Release -> next tick after 2 RUN cycles.
- Stop at 00:00:07 with best_valid=0 -> best=00:00:07, best_valid=1, new_best one cycle. Later stop at 00:00:09 -> best unchanged, no new_best. Then 00:00:05 -> best=00:00:05 with new_best.
- Same-cycle stop and prescaler wrap at 00:00:03 -> final=00:00:03, no tick. Same-cycle clear+stop -> IDLE, time 0, best unchanged.
- Assert reset during RUN at 00:00:04 with best valid -> all outputs 0 immediately; start is ignored until reset deasserts.

Source files
------------

// File: rtl/game_timer_ctrl_pkg.sv
// Shared definitions for the game timer controller: FSM state encoding,
// BCD time limits and the HH:MM:SS BCD increment helper.
package game_timer_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } timer_state_t;

    localparam logic [23:0] TIME_MAX_BCD    = 24'h995959;
    localparam logic [3:0]  BCD_LIMIT_UNITS = 4'd9;
    localparam logic [3:0]  BCD_LIMIT_TENS  = 4'd5;

    // Digit order is sec_1s(0), sec_10s(1), min_1s(2), min_10s(3), hr_1s(4), hr_10s(5).
    // The tens-of-seconds and tens-of-minutes digits roll over at 5.
    function automatic logic [3:0] digit_limit(input int idx);
        return ((idx == 1) || (idx == 3)) ? BCD_LIMIT_TENS : BCD_LIMIT_UNITS;
    endfunction

    // Ripple-carry increment of a packed HH:MM:SS BCD value.
    // The caller keeps the value below TIME_MAX_BCD, so hr_10s never passes 9.
    function automatic logic [23:0] bcd_hms_inc(input logic [23:0] t);
        logic [23:0] r;
        logic        carry;
        r     = t;
        carry = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == digit_limit(i)) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/game_timer_ctrl_if.sv
// Bundle between game logic (master) and the timer controller (slave):
// run-control events in, live/best BCD time and status flags out.
interface game_timer_ctrl_if;
    logic       start;
    logic       stop;
    logic       clear;
    logic       pause_sw;
    logic [3:0] sec_1s, sec_10s, min_1s, min_10s, hr_1s, hr_10s;
    logic [3:0] best_sec_1s, best_sec_10s, best_min_1s, best_min_10s, best_hr_1s, best_hr_10s;
    logic       best_valid;
    logic       new_best;
    logic       running;
    logic       tick_1Hz;
    logic       overflow;

    modport master (
        output start, stop, clear, pause_sw,
        input  sec_1s, sec_10s, min_1s, min_10s, hr_1s, hr_10s,
        input  best_sec_1s, best_sec_10s, best_min_1s, best_min_10s, best_hr_1s, best_hr_10s,
        input  best_valid, new_best, running, tick_1Hz, overflow
    );

    modport slave (
        input  start, stop, clear, pause_sw,
        output sec_1s, sec_10s, min_1s, min_10s, hr_1s, hr_10s,
        output best_sec_1s, best_sec_10s, best_min_1s, best_min_10s, best_hr_1s, best_hr_10s,
        output best_valid, new_best, running, tick_1Hz, overflow
    );
endinterface

// File: rtl/game_timer_ctrl_bcd_hms_counter.sv
// Six-digit BCD HH:MM:SS register. Clear wins over increment; an increment
// at 99:59:59 leaves the value unchanged (the owner flags overflow).
module bcd_hms_counter
    import game_timer_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        inc,
    output logic [23:0] time_bcd,
    output logic        at_max
);

    logic [23:0] time_q;

    // Time register: only written on clear or a non-saturated increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            time_q <= 24'h000000;
        end else if (clr) begin
            time_q <= 24'h000000;
        end else if (inc && !at_max) begin
            time_q <= bcd_hms_inc(time_q);
        end
    end

    assign time_bcd = time_q;
    assign at_max   = (time_q == TIME_MAX_BCD);

endmodule

// File: rtl/game_timer_ctrl.sv
// Game timer sequencer: run/pause/stop FSM, 1 Hz prescaler, live time
// counter and best (lowest) completed time tracking.
module game_timer_ctrl
    import game_timer_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic              clk,
    input  logic              reset,
    game_timer_ctrl_if.slave  bus
);

    localparam int            PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    timer_state_t  state;
    logic [PW-1:0] presc;
    logic [23:0]   live_bcd;
    logic [23:0]   best_bcd;
    logic          at_max;
    logic          wrap;
    logic          start_accept;
    logic          stop_accept;
    logic          cnt_clr;
    logic          cnt_inc;
    logic          best_take;
    logic          tick_q;
    logic          new_best_q;
    logic          running_q;
    logic          overflow_q;
    logic          best_valid_q;

    // Event decode: clear beats stop beats start; a stop on a wrap cycle suppresses the increment.
    always_comb begin
        wrap         = (presc == PRE_LAST);
        start_accept = !bus.clear && bus.start && ((state == ST_IDLE) || (state == ST_DONE));
        stop_accept  = !bus.clear && bus.stop && ((state == ST_RUN) || (state == ST_PAUSED));
        cnt_clr      = bus.clear || start_accept;
        cnt_inc      = (state == ST_RUN) && !bus.clear && !bus.stop && wrap;
        best_take    = !overflow_q && (!best_valid_q || (live_bcd < best_bcd));
    end

    bcd_hms_counter u_counter (
        .clk      (clk),
        .reset    (reset),
        .clr      (cnt_clr),
        .inc      (cnt_inc),
        .time_bcd (live_bcd),
        .at_max   (at_max)
    );

    // FSM with prescaler, status flags and best-time capture on entry to DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            presc        <= '0;
            tick_q       <= 1'b0;
            new_best_q   <= 1'b0;
            running_q    <= 1'b0;
            overflow_q   <= 1'b0;
            best_valid_q <= 1'b0;
            best_bcd     <= 24'h000000;
        end else begin
            tick_q     <= 1'b0;
            new_best_q <= 1'b0;
            if (bus.clear) begin
                state      <= ST_IDLE;
                presc      <= '0;
                overflow_q <= 1'b0;
                running_q  <= 1'b0;
            end else if (stop_accept) begin
                state     <= ST_DONE;
                running_q <= 1'b0;
                if (best_take) begin
                    best_bcd     <= live_bcd;
                    best_valid_q <= 1'b1;
                    new_best_q   <= 1'b1;
                end
            end else if (start_accept) begin
                state      <= ST_RUN;
                presc      <= '0;
                overflow_q <= 1'b0;
                running_q  <= 1'b1;
            end else begin
                case (state)
                    ST_RUN: begin
                        presc  <= wrap ? '0 : presc + PW'(1);
                        tick_q <= wrap;
                        if (wrap && at_max) begin
                            overflow_q <= 1'b1;
                        end
                        if (bus.pause_sw) begin
                            state     <= ST_PAUSED;
                            running_q <= 1'b0;
                        end
                    end
                    ST_PAUSED: begin
                        if (!bus.pause_sw) begin
                            state     <= ST_RUN;
                            running_q <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign {bus.hr_10s, bus.hr_1s, bus.min_10s, bus.min_1s, bus.sec_10s, bus.sec_1s} = live_bcd;
    assign {bus.best_hr_10s, bus.best_hr_1s, bus.best_min_10s, bus.best_min_1s,
            bus.best_sec_10s, bus.best_sec_1s} = best_bcd;
    assign bus.best_valid = best_valid_q;
    assign bus.new_best   = new_best_q;
    assign bus.running    = running_q;
    assign bus.tick_1Hz   = tick_q;
    assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Testbench for game_timer_ctrl: directed scenarios plus a random phase,
// all checked cycle by cycle against a seconds-based reference model.
module tb_game_timer_ctrl;

    localparam int TICK_DIV = 4;
    localparam int MAX_SEC  = 99 * 3600 + 59 * 60 + 59;
    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_PAUSED = 2;
    localparam int M_DONE   = 3;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    // Reference model: time kept as plain seconds, modes named after the spec states.
    int   m_mode;
    int   m_live;
    int   m_presc;
    int   m_best;
    bit   m_ovf;
    bit   m_best_valid;
    bit   m_new_best;
    bit   m_tick;

    game_timer_ctrl_if bus ();

    game_timer_ctrl #(.TICK_DIV(TICK_DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    function automatic logic [23:0] to_bcd(input int s);
        int hh, mm, ss;
        hh = s / 3600;
        mm = (s / 60) % 60;
        ss = s % 60;
        return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic logic [23:0] live_now();
        return {bus.hr_10s, bus.hr_1s, bus.min_10s, bus.min_1s, bus.sec_10s, bus.sec_1s};
    endfunction

    function automatic logic [23:0] best_now();
        return {bus.best_hr_10s, bus.best_hr_1s, bus.best_min_10s, bus.best_min_1s,
                bus.best_sec_10s, bus.best_sec_1s};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode       = M_IDLE;
        m_live       = 0;
        m_presc      = 0;
        m_best       = 0;
        m_ovf        = 0;
        m_best_valid = 0;
        m_new_best   = 0;
        m_tick       = 0;
    endtask

    task automatic model_clock(input bit st, input bit sp, input bit cl, input bit ps);
        m_tick     = 0;
        m_new_best = 0;
        if (cl) begin
            m_mode  = M_IDLE;
            m_live  = 0;
            m_presc = 0;
            m_ovf   = 0;
        end else if (sp && (m_mode == M_RUN || m_mode == M_PAUSED)) begin
            if (!m_ovf && (!m_best_valid || m_live < m_best)) begin
                m_best       = m_live;
                m_best_valid = 1;
                m_new_best   = 1;
            end
            m_mode = M_DONE;
        end else if (st && (m_mode == M_IDLE || m_mode == M_DONE)) begin
            m_mode  = M_RUN;
            m_live  = 0;
            m_presc = 0;
            m_ovf   = 0;
        end else if (m_mode == M_RUN) begin
            m_presc++;
            if (m_presc == TICK_DIV) begin
                m_presc = 0;
                m_tick  = 1;
                if (m_live == MAX_SEC) m_ovf = 1;
                else m_live++;
            end
            if (ps) m_mode = M_PAUSED;
        end else if (m_mode == M_PAUSED && !ps) begin
            m_mode = M_RUN;
        end
    endtask

    task automatic compare_all();
        checkOutput("live_time", 32'(live_now()), 32'(to_bcd(m_live)));
        checkOutput("best_time", 32'(best_now()), 32'(m_best_valid ? to_bcd(m_best) : 24'h0));
        checkOutput("best_valid", 32'(bus.best_valid), 32'(m_best_valid));
        checkOutput("new_best", 32'(bus.new_best), 32'(m_new_best));
        checkOutput("running", 32'(bus.running), 32'(m_mode == M_RUN));
        checkOutput("tick_1Hz", 32'(bus.tick_1Hz), 32'(m_tick));
        checkOutput("overflow", 32'(bus.overflow), 32'(m_ovf));
    endtask

    // One clock cycle: drive inputs, advance model at the edge, compare 1 time unit later.
    task automatic applyStimulus(input bit st, input bit sp, input bit cl, input bit ps);
        bus.start    = st;
        bus.stop     = sp;
        bus.clear    = cl;
        bus.pause_sw = ps;
        @(posedge clk);
        if (reset) model_reset();
        else model_clock(st, sp, cl, ps);
        #1;
        compare_all();
    endtask

    task automatic run_to(input int target, input int budget);
        for (int i = 0; i < budget && m_live != target; i++) applyStimulus(0, 0, 0, 0);
        checkOutput("reach_time", 32'(live_now()), 32'(to_bcd(target)));
    endtask

    task automatic run_to_presc(input int target);
        for (int i = 0; i < 2 * TICK_DIV && m_presc != target; i++) applyStimulus(0, 0, 0, 0);
    endtask

    initial begin
        bit ps_level;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.clear    = 1'b0;
        bus.pause_sw = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        reset = 1'b0;
        repeat (3) applyStimulus(0, 0, 0, 0);

        // Basic counting: 11 seconds, covering the sec_1s -> sec_10s carry.
        applyStimulus(1, 0, 0, 0);
        checkOutput("running_after_start", 32'(bus.running), 32'd1);
        repeat (11 * TICK_DIV) applyStimulus(0, 0, 0, 0);
        checkOutput("eleven_seconds", 32'(live_now()), 32'h000011);

        // Pause mid-second, hold 10 cycles, release.
        run_to_presc(2);
        repeat (10) applyStimulus(0, 0, 0, 1);
        repeat (2 * TICK_DIV) applyStimulus(0, 0, 0, 0);

        // Saturation at 99:59:59 with best_valid still 0; a stop then gives no best.
        applyStimulus(0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        force dut.u_counter.time_q = 24'h995958;
        #1;
        release dut.u_counter.time_q;
        m_live = MAX_SEC - 1;
        applyStimulus(0, 0, 0, 1);
        repeat (4 * TICK_DIV) applyStimulus(0, 0, 0, 0);
        checkOutput("saturated", 32'(live_now()), 32'h995959);
        checkOutput("overflow_set", 32'(bus.overflow), 32'd1);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("ovf_no_best", 32'(bus.best_valid), 32'd0);

        // Best time: 7 (new), 9 (not better), 5 (new).
        applyStimulus(1, 0, 0, 0);
        run_to(7, 100);
        applyStimulus(0, 1, 0, 0);
        checkOutput("best_first", 32'(best_now()), 32'h000007);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        run_to(9, 100);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        run_to(5, 100);
        applyStimulus(0, 1, 0, 0);
        checkOutput("best_improved", 32'(best_now()), 32'h000005);
        applyStimulus(0, 0, 0, 0);

        // Stop on the same cycle as a prescaler wrap at 00:00:03.
        applyStimulus(1, 0, 0, 0);
        run_to(3, 100);
        run_to_presc(TICK_DIV - 1);
        applyStimulus(0, 1, 0, 0);
        checkOutput("stop_wrap_final", 32'(live_now()), 32'h000003);
        applyStimulus(0, 0, 0, 0);

        // Clear and stop together while running.
        applyStimulus(1, 0, 0, 0);
        run_to(2, 100);
        applyStimulus(0, 1, 1, 0);
        checkOutput("clear_stop_time", 32'(live_now()), 32'h000000);
        applyStimulus(0, 0, 0, 0);

        // Minute/hour carry chain: 00:59:59 -> 01:00:00.
        applyStimulus(1, 0, 0, 0);
        run_to(3599, 20000);
        run_to(3600, 2 * TICK_DIV);
        checkOutput("hour_roll", 32'(live_now()), 32'h010000);
        applyStimulus(0, 0, 1, 0);

        // Random event mix.
        ps_level = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) ps_level = ~ps_level;
            applyStimulus($urandom_range(0, 15) == 0, $urandom_range(0, 39) == 0,
                          $urandom_range(0, 79) == 0, ps_level);
        end

        // Asynchronous reset mid-run with a valid best time.
        applyStimulus(0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0);
        run_to(4, 100);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        #2;
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0);
        checkOutput("idle_after_reset", 32'(bus.running), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
